// File: rtl/hubris_bp_defs.sv
// Shared definitions for the fetch-stage branch predictor: default sizing,
// 2-bit direction counter encodings and the RISC-V control-transfer opcode/funct3 codes.
// No ports; no latency or backpressure (declarations only).
package hubris_bp_defs;

    localparam int unsigned BP_ADDR_WIDTH_DEF  = 32;
    localparam int unsigned BP_BTB_ENTRIES_DEF = 16;

    // Direction counter: bit 1 is the taken/not-taken prediction.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter, used as the next-state function of a BTB entry.
// Latency: combinational. Backpressure: none.
// Ports: ctr_i current value, en_i step enable, up_i direction (1=+1, 0=-1), ctr_o next value.
module sat_counter2
    import hubris_bp_defs::*;
(
    input  logic [1:0] ctr_i,
    input  logic       en_i,
    input  logic       up_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (en_i) begin
            if (up_i) begin
                if (ctr_i != CTR_ST) begin
                    ctr_o = ctr_i + 2'd1;
                end
            end else begin
                if (ctr_i != CTR_SNT) begin
                    ctr_o = ctr_i - 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; combinational fetch lookup, resolve-stage update.
// Latency: prediction same cycle as fetch_pc; mispredict/redirect registered one cycle after upd_valid.
// Backpressure: none; one update accepted per cycle, lookups are read-before-write.
// Ports: clk/reset_n; fetch_pc -> pred_taken/pred_addr; upd_* resolved-instruction strobe;
//        mispredict/redirect_addr flush pulse; stat_branches/stat_mispredicts saturating counters.
module branch_predictor
    import hubris_bp_defs::*;
#(
    parameter int unsigned ADDR_WIDTH_IN_BIT = BP_ADDR_WIDTH_DEF,
    parameter int unsigned BTB_ENTRIES       = BP_BTB_ENTRIES_DEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADDR_WIDTH_IN_BIT-1:0] fetch_pc,
    output logic                         pred_taken,
    output logic [ADDR_WIDTH_IN_BIT-1:0] pred_addr,
    input  logic                         upd_valid,
    input  logic [ADDR_WIDTH_IN_BIT-1:0] upd_pc,
    input  logic                         upd_is_branch,
    input  logic                         upd_is_jump,
    input  logic                         upd_taken,
    input  logic [ADDR_WIDTH_IN_BIT-1:0] upd_target,
    input  logic                         upd_pred_taken,
    input  logic [ADDR_WIDTH_IN_BIT-1:0] upd_pred_addr,
    output logic                         mispredict,
    output logic [ADDR_WIDTH_IN_BIT-1:0] redirect_addr,
    output logic [31:0]                  stat_branches,
    output logic [31:0]                  stat_mispredicts
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = ADDR_WIDTH_IN_BIT - IDX_W - 2;
    localparam logic [ADDR_WIDTH_IN_BIT-1:0] PC_STEP = ADDR_WIDTH_IN_BIT'(4);

    // Entry storage (flops)
    logic                         valid_q  [BTB_ENTRIES];
    logic                         jump_q   [BTB_ENTRIES];
    logic [1:0]                   ctr_q    [BTB_ENTRIES];
    logic [TAG_W-1:0]             tag_q    [BTB_ENTRIES];
    logic [ADDR_WIDTH_IN_BIT-1:0] target_q [BTB_ENTRIES];

    logic                         mispredict_q, mispredict_d;
    logic [ADDR_WIDTH_IN_BIT-1:0] redirect_q, redirect_d;
    logic [31:0]                  stat_br_q, stat_br_d;
    logic [31:0]                  stat_mp_q, stat_mp_d;

    // ---------------- Fetch lookup ----------------
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[ADDR_WIDTH_IN_BIT-1:IDX_W+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign pred_taken = f_hit && (jump_q[f_idx] || ctr_q[f_idx][1]);
    assign pred_addr  = pred_taken ? target_q[f_idx] : (fetch_pc + PC_STEP);

    // ---------------- Resolve-stage update ----------------
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             u_cti;
    logic             u_eff_taken;
    logic             u_alloc;
    logic             u_inval;
    logic             u_ctr_we;
    logic             u_tgt_we;
    logic [1:0]       u_ctr_nxt;
    logic [ADDR_WIDTH_IN_BIT-1:0] correct_addr;
    logic             mis_evt;

    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[ADDR_WIDTH_IN_BIT-1:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_cti = upd_is_branch || upd_is_jump;

    // A non-control-transfer instruction always falls through, whatever upd_taken says.
    assign u_eff_taken = upd_taken && u_cti;

    assign u_alloc  = upd_valid && !u_hit && u_eff_taken;
    assign u_inval  = upd_valid && u_hit && !u_cti;
    assign u_ctr_we = upd_valid && u_hit && upd_is_branch;
    assign u_tgt_we = u_alloc
                   || (upd_valid && u_hit && (upd_is_jump || (upd_is_branch && upd_taken)));

    sat_counter2 u_sat_counter2 (
        .ctr_i (ctr_q[u_idx]),
        .en_i  (u_ctr_we),
        .up_i  (upd_taken),
        .ctr_o (u_ctr_nxt)
    );

    // Control bits: reset so every lookup misses immediately after reset_n falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                jump_q[i]  <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (u_alloc) begin
            valid_q[u_idx] <= 1'b1;
            jump_q[u_idx]  <= upd_is_jump;
            ctr_q[u_idx]   <= CTR_WT;
        end else if (u_inval) begin
            valid_q[u_idx] <= 1'b0;
        end else if (u_ctr_we) begin
            ctr_q[u_idx] <= u_ctr_nxt;
        end
    end

    // Payload: unreset. A write landing while reset is low is harmless because
    // the entry's valid bit is held clear.
    always_ff @(posedge clk) begin
        if (u_alloc) begin
            tag_q[u_idx] <= u_tag;
        end
        if (u_tgt_we) begin
            target_q[u_idx] <= upd_target;
        end
    end

    // ---------------- Mispredict detection and statistics ----------------
    always_comb begin
        correct_addr = u_eff_taken ? upd_target : (upd_pc + PC_STEP);
        mis_evt      = upd_valid
                    && ((u_eff_taken != upd_pred_taken)
                        || (u_eff_taken && (upd_target != upd_pred_addr)));

        mispredict_d = mis_evt;
        redirect_d   = mis_evt ? correct_addr : redirect_q;

        stat_br_d = stat_br_q;
        if (upd_valid && u_cti && (stat_br_q != 32'hFFFF_FFFF)) begin
            stat_br_d = stat_br_q + 32'd1;
        end

        stat_mp_d = stat_mp_q;
        if (mis_evt && (stat_mp_q != 32'hFFFF_FFFF)) begin
            stat_mp_d = stat_mp_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            stat_br_q    <= '0;
            stat_mp_q    <= '0;
        end else begin
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            stat_br_q    <= stat_br_d;
            stat_mp_q    <= stat_mp_d;
        end
    end

    assign mispredict       = mispredict_q;
    assign redirect_addr    = redirect_q;
    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus pushes expected lookups, stats and
// per-update mispredict results; a negedge monitor pops and compares.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_addr;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_is_branch = 1'b0;
    logic        upd_is_jump = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_addr = '0;
    logic        mispredict;
    logic [31:0] redirect_addr;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    always #5 clk = ~clk;

    branch_predictor #(
        .ADDR_WIDTH_IN_BIT (32),
        .BTB_ENTRIES       (16)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .fetch_pc         (fetch_pc),
        .pred_taken       (pred_taken),
        .pred_addr        (pred_addr),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_is_branch    (upd_is_branch),
        .upd_is_jump      (upd_is_jump),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_addr    (upd_pred_addr),
        .mispredict       (mispredict),
        .redirect_addr    (redirect_addr),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    // kind 0: prediction (a=pred_taken, b=pred_addr); kind 1: stats (a=branches, b=mispredicts)
    typedef struct {
        int          kind;
        string       name;
        logic [31:0] a;
        logic [31:0] b;
    } chk_t;

    typedef struct {
        logic        mp;
        logic [31:0] addr;
    } mp_t;

    chk_t chk_q[$];
    mp_t  mp_q[$];
    logic        chk_vld = 1'b0;
    logic        upd_d = 1'b0;
    logic [31:0] last_redirect = '0;
    int total = 0;
    int bad = 0;

    task automatic compare(input string nm, input logic [31:0] act_a, input logic [31:0] exp_a,
                           input logic [31:0] act_b, input logic [31:0] exp_b);
        total++;
        if ((act_a !== exp_a) || (act_b !== exp_b)) begin
            bad++;
            $display("FAIL %s: got %h/%h expected %h/%h", nm, act_a, act_b, exp_a, exp_b);
        end
    endtask

    // An update accepted on this edge owes one mispredict result next cycle.
    always @(posedge clk) upd_d <= upd_valid && reset_n;

    // Monitor
    always @(negedge clk) begin
        chk_t        c;
        mp_t         m;
        logic [31:0] exp_r;
        if (!reset_n) last_redirect = '0;
        if (chk_vld) begin
            if (chk_q.size() == 0) begin
                total++; bad++;
                $display("FAIL chk_underflow: got check strobe expected queued entry");
            end else begin
                c = chk_q.pop_front();
                if (c.kind == 0)
                    compare(c.name, 32'(pred_taken), c.a, pred_addr, c.b);
                else
                    compare(c.name, stat_branches, c.a, stat_mispredicts, c.b);
            end
        end
        if (upd_d) begin
            if (mp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL mp_underflow: got update result expected queued entry");
            end else begin
                m = mp_q.pop_front();
                exp_r = m.mp ? m.addr : last_redirect;
                compare("mp_after_upd", 32'(mispredict), 32'(m.mp), redirect_addr, exp_r);
                last_redirect = exp_r;
            end
        end else begin
            compare("mp_idle", 32'(mispredict), 32'd0, redirect_addr, last_redirect);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        chk_vld   = 1'b0;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic br, input logic jmp, input logic tk,
                          input logic [31:0] tgt, input logic ppt, input logic [31:0] ppa,
                          input logic exp_mp, input logic [31:0] exp_addr);
        mp_t m;
        upd_valid = 1'b1; upd_pc = pc; upd_is_branch = br; upd_is_jump = jmp;
        upd_taken = tk; upd_target = tgt; upd_pred_taken = ppt; upd_pred_addr = ppa;
        m.mp = exp_mp; m.addr = exp_addr;
        mp_q.push_back(m);
    endtask

    task automatic do_look(input string nm, input logic [31:0] pc, input logic t, input logic [31:0] a);
        chk_t c;
        fetch_pc = pc; chk_vld = 1'b1;
        c.kind = 0; c.name = nm; c.a = 32'(t); c.b = a;
        chk_q.push_back(c);
    endtask

    task automatic do_stats(input string nm, input logic [31:0] b, input logic [31:0] m);
        chk_t c;
        chk_vld = 1'b1;
        c.kind = 1; c.name = nm; c.a = b; c.b = m;
        chk_q.push_back(c);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        do_look("rst_pred", 32'h100, 1'b0, 32'h104); tick();
        do_look("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0); tick();
        do_stats("rst_stats", 0, 0); tick();

        // BEQ 0x100: taken alloc, then not-taken twice (10->01->00), then saturate at 00
        do_upd(32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 1, 32'h80); tick();
        do_look("beq_alloc", 32'h100, 1'b1, 32'h80); tick();
        do_upd(32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 1, 32'h104); tick();
        do_look("beq_wnt", 32'h100, 1'b0, 32'h104); tick();
        do_upd(32'h100, 1, 0, 0, 32'h80, 0, 32'h104, 0, 32'h0); tick();
        do_look("beq_snt", 32'h100, 1'b0, 32'h104); tick();
        do_upd(32'h100, 1, 0, 0, 32'h80, 0, 32'h104, 0, 32'h0); tick();
        do_look("beq_snt_sat", 32'h100, 1'b0, 32'h104); tick();
        // Correctly predicted taken BNE at 0x104 allocates; pc[1:0] ignored on lookup
        do_upd(32'h104, 1, 0, 1, 32'h40, 1, 32'h40, 0, 32'h0); tick();
        do_look("bne_lowbits", 32'h106, 1'b1, 32'h40); tick();
        do_stats("pre_rst_stats", 5, 2); tick();

        // Reset asserted mid-update (a would-be mispredict); outputs clear before any edge
        upd_valid = 1'b1; upd_pc = 32'h180; upd_is_branch = 1'b1; upd_is_jump = 1'b0;
        upd_taken = 1'b1; upd_target = 32'h500; upd_pred_taken = 1'b0; upd_pred_addr = 32'h184;
        #1 reset_n = 1'b0;
        do_stats("rst_async_stats", 0, 0); tick();
        do_look("rst_empty_100", 32'h100, 1'b0, 32'h104); tick();
        do_look("rst_empty_104", 32'h104, 1'b0, 32'h108); tick();
        reset_n = 1'b1;
        do_look("post_rst_180", 32'h180, 1'b0, 32'h184); tick();
        tick();
        do_stats("post_rst_stats", 0, 0); tick();

        // JALR 0x200: allocate to 0x300, then retarget to 0x400
        do_upd(32'h200, 0, 1, 1, 32'h300, 0, 32'h204, 1, 32'h300); tick();
        do_look("jalr_alloc", 32'h200, 1'b1, 32'h300); tick();
        do_upd(32'h200, 0, 1, 1, 32'h400, 1, 32'h300, 1, 32'h400); tick();
        do_look("jalr_retarget", 32'h200, 1'b1, 32'h400); tick();

        // Same-cycle update and lookup of 0x100 (same index as 0x200, evicts it)
        do_upd(32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 1, 32'h80);
        do_look("rbw_old", 32'h100, 1'b0, 32'h104); tick();
        do_look("rbw_new", 32'h100, 1'b1, 32'h80); tick();
        do_look("alias_evict", 32'h200, 1'b0, 32'h204); tick();

        // Counter 10->11->11(sat)->10, still predicting taken
        do_upd(32'h100, 1, 0, 1, 32'h80, 1, 32'h80, 0, 32'h0); tick();
        do_upd(32'h100, 1, 0, 1, 32'h80, 1, 32'h80, 0, 32'h0); tick();
        do_upd(32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 1, 32'h104); tick();
        do_look("beq_st_sat", 32'h100, 1'b1, 32'h80); tick();
        // Taken to a new target: address-only mispredict
        do_upd(32'h100, 1, 0, 1, 32'h90, 1, 32'h80, 1, 32'h90); tick();
        do_look("beq_retarget", 32'h100, 1'b1, 32'h90); tick();
        // Non-CTI hitting the entry: invalidate, mispredict to pc+4
        do_upd(32'h100, 0, 0, 0, 32'h0, 1, 32'h90, 1, 32'h104); tick();
        do_look("inval", 32'h100, 1'b0, 32'h104); tick();
        // Miss, not taken: no allocation
        do_upd(32'h300, 1, 0, 0, 32'h20, 0, 32'h304, 0, 32'h0); tick();
        do_look("miss_nt", 32'h300, 1'b0, 32'h304); tick();
        do_stats("final_stats", 8, 6); tick();

        tick();
        total++;
        if ((chk_q.size() != 0) || (mp_q.size() != 0)) begin
            bad++;
            $display("FAIL queue_drain: got %0d/%0d pending expected 0/0", chk_q.size(), mp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
